simon_game_fsm: RTL and testbench
=================================

SIMON_GAME_FSM -- requirements
Module: simon_game_fsm

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 16; last round number, legal range 1 to 31.
REQ-002 SHALL have parameter ROUND_W, default 5; width of the round counter and check_round, at least clog2(MAX_ROUNDS+1).
REQ-003 SHALL have parameter SPEED_W, default 3; width of speed.
REQ-004 SHALL have parameter ROUNDS_PER_SPEED, default 4; completed rounds per speed step.
REQ-005 SHALL have parameter TIMEOUT_PULSES, default 8; player idle limit in pulses, used only under SIMON_TIMEOUT_EN.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- go  in  1  player start/restart request.
- guess_valid  in  1  one-cycle strobe; a player guess has been presented to the checker.
- result  in  1  checker: last guess matched.
- empty  in  1  checker: all guesses for the round consumed.
- pulse  in  1  flasher tick.
- start  out  1  one-cycle RNG start.
- rst_seedgen  out  1  one-cycle seed-register reset.
- load_colour  out  1  one-cycle advance of the sequence colour.
- load_speed  out  1  one-cycle flasher speed load.
- speed  out  SPEED_W  current speed level.
- flash_colour  out  1  LED display enable.
- player_turn  out  1  guesses are accepted.
- check_round  out  ROUND_W  current round number, 1-based.
- game_over  out  1  game ended.
- win  out  1  game ended in a win; valid when game_over=1.

Function
REQ-008 States SHALL be IDLE, SEED, LDSPD, LOADC, FLASH, GAP, PLAY, CHECK, WIN and LOSE.
REQ-009 IDLE with go=1 SHALL go to SEED; start and rst_seedgen SHALL be 1 for that SEED cycle only; round SHALL be set to 1 and the speed counter to 0.
REQ-010 SEED SHALL go to LDSPD after 1 cycle; LDSPD SHALL assert load_speed for 1 cycle, clear the step index, and go to LOADC.
REQ-011 LOADC SHALL assert load_colour for 1 cycle and go to FLASH.
REQ-012 FLASH SHALL hold flash_colour=1 until pulse=1 and then go to GAP.
REQ-013 GAP SHALL wait for pulse=1 and increment the step index; if index+1 equals round it SHALL go to PLAY, otherwise to LOADC.
REQ-014 PLAY SHALL hold player_turn=1; guess_valid=1 SHALL move it to CHECK.
REQ-015 CHECK SHALL last 1 cycle and sample result/empty:
- result=0: go to LOSE.
- result=1 and empty=0: go to PLAY.
- result=1, empty=1, round=MAX_ROUNDS: go to WIN.
- otherwise: increment round and go to LDSPD.
REQ-016 The speed counter SHALL increment once every ROUNDS_PER_SPEED completed rounds and saturate at 2^SPEED_W-1; speed SHALL update in the same cycle as the round increment.
REQ-017 WIN SHALL drive game_over=1 and win=1; LOSE SHALL drive game_over=1 and win=0; both SHALL hold until go=1 and then go to SEED.
REQ-018 guess_valid outside PLAY SHALL be ignored, and go outside IDLE/WIN/LOSE SHALL be ignored.
REQ-019 pulse and guess_valid arriving in the same PLAY cycle: the guess SHALL take priority.
REQ-020 check_round SHALL equal round in all states except IDLE, where it SHALL be 0.
REQ-021 All outputs SHALL be registered; a transition SHALL take exactly 1 cycle after its qualifying input.

Reset
REQ-022 rst=1 SHALL force IDLE, round=0, speed=0, index=0, and all 1-bit outputs to 0, immediately and at any point in the game.
REQ-023 After rst falls, the block SHALL stay in IDLE until go=1.

Configuration
REQ-024 With SIMON_TIMEOUT_EN defined:
- PLAY SHALL count pulses and go to LOSE after TIMEOUT_PULSES pulses with no guess_valid.
- The count SHALL clear on entering PLAY and on every guess_valid.
REQ-025 Without SIMON_TIMEOUT_EN, no timeout logic SHALL exist and PLAY SHALL wait indefinitely.

Structure
REQ-026 Package simon_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-027 Round and speed counting SHALL live in sub-module simon_round_ctr (inc, clr, round, speed).

Verification
REQ-028 Perfect game, MAX_ROUNDS=3: go, then all results 1 -> flash counts 1, 2 and 3; game_over=1, win=1.
REQ-029 Round 2 guess with result=0 -> LOSE; game_over=1, win=0; go -> SEED with start=1 for exactly 1 cycle.
REQ-030 ROUNDS_PER_SPEED=4, SPEED_W=2, 16 correct rounds -> speed steps 0,1,2,3 and stays at 3.
REQ-031 rst pulsed during FLASH in round 3 -> all outputs 0 and check_round=0 immediately; go restarts at round 1.
REQ-032 SIMON_TIMEOUT_EN, TIMEOUT_PULSES=8, no guess in PLAY -> LOSE on the 8th pulse; a guess at the 7th pulse clears the count.
REQ-033 guess_valid in FLASH, and go in PLAY -> no state change.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encoding and
// default parameter values used by simon_game_fsm and simon_round_ctr.
package simon_pkg;

  localparam int DEF_MAX_ROUNDS       = 16;
  localparam int DEF_ROUND_W          = 5;
  localparam int DEF_SPEED_W          = 3;
  localparam int DEF_ROUNDS_PER_SPEED = 4;
  localparam int DEF_TIMEOUT_PULSES   = 8;

  typedef enum logic [3:0] {
    IDLE,
    SEED,
    LDSPD,
    LOADC,
    FLASH,
    GAP,
    PLAY,
    CHECK,
    WIN,
    LOSE
  } state_t;

endpackage

// File: rtl/simon_round_ctr.sv
// Round number and speed level counters for the Simon game.
// clr starts a new game at round 1 / speed 0; inc completes one round.
module simon_round_ctr import simon_pkg::*; #(
  parameter int ROUND_W          = DEF_ROUND_W,
  parameter int SPEED_W          = DEF_SPEED_W,
  parameter int ROUNDS_PER_SPEED = DEF_ROUNDS_PER_SPEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [ROUND_W-1:0] round,
  output logic [SPEED_W-1:0] speed
);

  localparam logic [ROUND_W-1:0] DONE_LAST = ROUND_W'(ROUNDS_PER_SPEED - 1);

  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] done_q, done_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  // done_q counts completed rounds within the current speed step
  always_comb begin
    round_d = round_q;
    done_d  = done_q;
    speed_d = speed_q;
    if (clr) begin
      round_d = ROUND_W'(1);
      done_d  = '0;
      speed_d = '0;
    end else if (inc) begin
      round_d = round_q + ROUND_W'(1);
      if (done_q == DONE_LAST) begin
        done_d = '0;
        if (speed_q != '1) begin
          speed_d = speed_q + SPEED_W'(1);
        end
      end else begin
        done_d = done_q + ROUND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q <= '0;
      done_q  <= '0;
      speed_q <= '0;
    end else begin
      round_q <= round_d;
      done_q  <= done_d;
      speed_q <= speed_d;
    end
  end

  assign round = round_q;
  assign speed = speed_q;

endmodule

// File: rtl/simon_game_fsm.sv
// Simon game controller: seeds the RNG, flashes a growing colour sequence,
// then checks the player's guesses. Define SIMON_TIMEOUT_EN for a player idle timeout.
module simon_game_fsm import simon_pkg::*; #(
  parameter int MAX_ROUNDS       = DEF_MAX_ROUNDS,
  parameter int ROUND_W          = DEF_ROUND_W,
  parameter int SPEED_W          = DEF_SPEED_W,
  parameter int ROUNDS_PER_SPEED = DEF_ROUNDS_PER_SPEED,
  parameter int TIMEOUT_PULSES   = DEF_TIMEOUT_PULSES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               guess_valid,
  input  logic               result,
  input  logic               empty,
  input  logic               pulse,
  output logic               start,
  output logic               rst_seedgen,
  output logic               load_colour,
  output logic               load_speed,
  output logic [SPEED_W-1:0] speed,
  output logic               flash_colour,
  output logic               player_turn,
  output logic [ROUND_W-1:0] check_round,
  output logic               game_over,
  output logic               win
);

  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 31) begin : g_bad_max_rounds
    $error("simon_game_fsm: MAX_ROUNDS must be 1..31");
  end
  if (ROUNDS_PER_SPEED < 1 || TIMEOUT_PULSES < 1) begin : g_bad_counts
    $error("simon_game_fsm: ROUNDS_PER_SPEED and TIMEOUT_PULSES must be >= 1");
  end

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] idx_q, idx_d, idx_inc;
  logic [ROUND_W-1:0] round;
  logic               inc, clr;
  logic               start_q, load_colour_q, load_speed_q;
  logic               flash_q, player_turn_q, game_over_q, win_q;

`ifdef SIMON_TIMEOUT_EN
  localparam int               TO_W    = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_PULSES - 1);
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
`endif

  simon_round_ctr #(
    .ROUND_W          (ROUND_W),
    .SPEED_W          (SPEED_W),
    .ROUNDS_PER_SPEED (ROUNDS_PER_SPEED)
  ) u_round_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr),
    .round (round),
    .speed (speed)
  );

  assign idx_inc = idx_q + ROUND_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inc     = 1'b0;
    clr     = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    to_cnt_d = (state_q == PLAY) ? to_cnt_q : '0;
`endif
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (go) begin
          state_d = SEED;
          clr     = 1'b1;
        end
      end
      SEED:  state_d = LDSPD;
      LDSPD: begin
        idx_d   = '0;
        state_d = LOADC;
      end
      LOADC: state_d = FLASH;
      FLASH: if (pulse) state_d = GAP;
      // one colour has been shown per GAP; the round shows `round` colours
      GAP: begin
        if (pulse) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == round) ? PLAY : LOADC;
        end
      end
      PLAY: begin
        if (guess_valid) begin
          state_d = CHECK;
`ifdef SIMON_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (pulse) begin
          if (to_cnt_q == TO_LAST) state_d = LOSE;
          else                     to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      CHECK: begin
        if (!result)                   state_d = LOSE;
        else if (!empty)               state_d = PLAY;
        else if (round == LAST_ROUND)  state_d = WIN;
        else begin
          inc     = 1'b1;
          state_d = LDSPD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
`ifdef SIMON_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef SIMON_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Outputs are decoded from the next state so they change with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q       <= 1'b0;
      load_colour_q <= 1'b0;
      load_speed_q  <= 1'b0;
      flash_q       <= 1'b0;
      player_turn_q <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      start_q       <= (state_d == SEED);
      load_colour_q <= (state_d == LOADC);
      load_speed_q  <= (state_d == LDSPD);
      flash_q       <= (state_d == FLASH);
      player_turn_q <= (state_d == PLAY);
      game_over_q   <= (state_d == WIN) || (state_d == LOSE);
      win_q         <= (state_d == WIN);
    end
  end

  assign start        = start_q;
  assign rst_seedgen  = start_q;
  assign load_colour  = load_colour_q;
  assign load_speed   = load_speed_q;
  assign flash_colour = flash_q;
  assign player_turn  = player_turn_q;
  assign game_over    = game_over_q;
  assign win          = win_q;
  assign check_round  = round;

endmodule

// File: tb/tb_simon_game_fsm.sv
// Self-checking bench for simon_game_fsm: random pulse/guess timing checked
// against a round/flash/speed model of the game rules.
module tb_simon_game_fsm;

  localparam int MAXR = 20;
  localparam int RW   = 5;
  localparam int SW   = 2;
  localparam int RPS  = 4;
  localparam int TP   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk, rst, go, guess_valid, result, empty, pulse;
  logic          start, rst_seedgen, load_colour, load_speed;
  logic [SW-1:0] speed;
  logic          flash_colour, player_turn, game_over, win;
  logic [RW-1:0] check_round;

  int nvec = 0;
  int nerr = 0;

  simon_game_fsm #(
    .MAX_ROUNDS       (MAXR),
    .ROUND_W          (RW),
    .SPEED_W          (SW),
    .ROUNDS_PER_SPEED (RPS),
    .TIMEOUT_PULSES   (TP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .guess_valid  (guess_valid),
    .result       (result),
    .empty        (empty),
    .pulse        (pulse),
    .start        (start),
    .rst_seedgen  (rst_seedgen),
    .load_colour  (load_colour),
    .load_speed   (load_speed),
    .speed        (speed),
    .flash_colour (flash_colour),
    .player_turn  (player_turn),
    .check_round  (check_round),
    .game_over    (game_over),
    .win          (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; go = 1'b0; guess_valid = 1'b0; result = 1'b0; empty = 1'b0; pulse = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic start_game;
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  // Runs one flash phase starting from LDSPD; stops when the player's turn begins
  task automatic flash_phase(output int nLoad, output int nFlash, output bit tmo);
    bit prevFlash;
    prevFlash = 1'b0;
    nLoad = 0; nFlash = 0; tmo = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (load_colour) nLoad++;
      if (flash_colour && !prevFlash) nFlash++;
      prevFlash = flash_colour;
      if (player_turn) begin
        tmo = 1'b0;
        break;
      end
      pulse = ($urandom_range(0, 2) == 0);
    end
    pulse = 1'b0;
  endtask

  // Idles in PLAY with some pulses, presents a guess, ends after the CHECK cycle
  task automatic guess(input bit res, input bit emp, input int nPulse, input bit pulseWithGuess,
                       output bit ptInCheck);
    for (int i = 0; i < nPulse; i++) begin
      pulse = 1'b1;
      tick;
      pulse = 1'b0;
      if ($urandom_range(0, 1) == 1) tick;
    end
    guess_valid = 1'b1; result = res; empty = emp; pulse = pulseWithGuess;
    tick;
    ptInCheck = player_turn;
    guess_valid = 1'b0; pulse = 1'b0;
    tick;
    result = 1'b0; empty = 1'b0;
  endtask

  function automatic int rand_pulses();
`ifdef SIMON_TIMEOUT_EN
    return $urandom_range(0, TP - 1);
`else
    return $urandom_range(0, 3);
`endif
  endfunction

  function automatic int exp_speed(input int r);
    int s;
    s = (r - 1) / RPS;
    return (s > SMAX) ? SMAX : s;
  endfunction

  task automatic test_reset;
    logic [7:0] outs;
    rst = 1'b0; go = 1'b0; guess_valid = 1'b0; result = 1'b0; empty = 1'b0; pulse = 1'b0;
    #2 rst = 1'b1;
    #1;
    outs = {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, game_over, win};
    nvec++;
    if (outs !== 8'h00) begin
      nerr++; $display("[TB] FAIL reset_outputs: got %b, expected 00000000", outs);
    end
    nvec++;
    if (check_round !== '0 || speed !== '0) begin
      nerr++; $display("[TB] FAIL reset_round_speed: got %0d/%0d, expected 0/0", check_round, speed);
    end
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      guess_valid = 1'($urandom_range(0, 1)); pulse = 1'($urandom_range(0, 1));
      result = 1'($urandom_range(0, 1)); empty = 1'($urandom_range(0, 1));
      tick;
      outs = {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, game_over, win};
      nvec++;
      if (outs !== 8'h00 || check_round !== '0) begin
        nerr++; $display("[TB] FAIL idle_hold: got %b round %0d, expected 00000000 round 0", outs, check_round);
      end
    end
    guess_valid = 1'b0; pulse = 1'b0; result = 1'b0; empty = 1'b0;
  endtask

  task automatic test_perfect_game;
    int nLoad, nFlash; bit tmo, ptc;
    do_reset;
    start_game;
    nvec++;
    if (start !== 1'b1 || rst_seedgen !== 1'b1) begin
      nerr++; $display("[TB] FAIL pg_seed: got start %b seed %b, expected 1 1", start, rst_seedgen);
    end
    tick;
    for (int r = 1; r <= MAXR; r++) begin
      nvec++;
      if (load_speed !== 1'b1 || check_round !== RW'(r) || speed !== SW'(exp_speed(r))) begin
        nerr++; $display("[TB] FAIL pg_ldspd r%0d: got ld %b round %0d speed %0d, expected 1 %0d %0d",
                         r, load_speed, check_round, speed, r, exp_speed(r));
      end
      flash_phase(nLoad, nFlash, tmo);
      nvec++;
      if (tmo !== 1'b0 || nLoad != r || nFlash != r) begin
        nerr++; $display("[TB] FAIL pg_flashes r%0d: got loads %0d flashes %0d tmo %b, expected %0d %0d 0",
                         r, nLoad, nFlash, tmo, r, r);
      end
      for (int g = 0; g < r; g++) begin
        guess(1'b1, (g == r - 1), rand_pulses(), 1'($urandom_range(0, 1)), ptc);
        nvec++;
        if (ptc !== 1'b0) begin
          nerr++; $display("[TB] FAIL pg_check_turn r%0d: got %b, expected 0", r, ptc);
        end
        if (g < r - 1) begin
          nvec++;
          if (player_turn !== 1'b1 || game_over !== 1'b0) begin
            nerr++; $display("[TB] FAIL pg_replay r%0d g%0d: got turn %b over %b, expected 1 0",
                             r, g, player_turn, game_over);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (game_over !== 1'b1 || win !== 1'b1 || check_round !== RW'(MAXR)) begin
        nerr++; $display("[TB] FAIL pg_win: got over %b win %b round %0d, expected 1 1 %0d",
                         game_over, win, check_round, MAXR);
      end
      guess_valid = 1'($urandom_range(0, 1)); pulse = 1'($urandom_range(0, 1));
      tick;
    end
    guess_valid = 1'b0; pulse = 1'b0;
  endtask

  task automatic test_lose_restart;
    int nLoad, nFlash, bad; bit tmo, ptc;
    do_reset;
    start_game;
    tick;
    flash_phase(nLoad, nFlash, tmo);
    guess(1'b1, 1'b1, rand_pulses(), 1'b0, ptc);
    nvec++;
    if (load_speed !== 1'b1 || check_round !== RW'(2)) begin
      nerr++; $display("[TB] FAIL lose_r2_entry: got ld %b round %0d, expected 1 2", load_speed, check_round);
    end
    flash_phase(nLoad, nFlash, tmo);
    bad = $urandom_range(0, 1);
    for (int g = 0; g <= bad; g++) begin
      guess((g != bad), (g == 1), rand_pulses(), 1'b0, ptc);
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (game_over !== 1'b1 || win !== 1'b0 || player_turn !== 1'b0) begin
        nerr++; $display("[TB] FAIL lose_state (bad guess %0d): got over %b win %b turn %b, expected 1 0 0",
                         bad, game_over, win, player_turn);
      end
      guess_valid = 1'($urandom_range(0, 1)); pulse = 1'($urandom_range(0, 1));
      tick;
    end
    guess_valid = 1'b0; pulse = 1'b0;
    start_game;
    nvec++;
    if (start !== 1'b1 || game_over !== 1'b0 || check_round !== RW'(1)) begin
      nerr++; $display("[TB] FAIL lose_restart: got start %b over %b round %0d, expected 1 0 1",
                       start, game_over, check_round);
    end
    tick;
    nvec++;
    if (start !== 1'b0 || rst_seedgen !== 1'b0 || load_speed !== 1'b1) begin
      nerr++; $display("[TB] FAIL lose_start_width: got start %b seed %b ld %b, expected 0 0 1",
                       start, rst_seedgen, load_speed);
    end
  endtask

  task automatic test_ignored;
    bit ptc;
    do_reset;
    start_game;
    tick; tick; tick;
    nvec++;
    if (flash_colour !== 1'b1) begin
      nerr++; $display("[TB] FAIL ign_flash_entry: got %b, expected 1", flash_colour);
    end
    guess_valid = 1'b1; result = 1'b1; empty = 1'b1; go = 1'b1;
    tick; tick;
    guess_valid = 1'b0; result = 1'b0; empty = 1'b0; go = 1'b0;
    nvec++;
    if (flash_colour !== 1'b1 || player_turn !== 1'b0 || start !== 1'b0) begin
      nerr++; $display("[TB] FAIL ign_guess_in_flash: got flash %b turn %b start %b, expected 1 0 0",
                       flash_colour, player_turn, start);
    end
    pulse = 1'b1;
    tick; tick;
    pulse = 1'b0;
    nvec++;
    if (player_turn !== 1'b1) begin
      nerr++; $display("[TB] FAIL ign_reach_play: got %b, expected 1", player_turn);
    end
    go = 1'b1;
    tick;
    go = 1'b0;
    nvec++;
    if (player_turn !== 1'b1 || start !== 1'b0 || check_round !== RW'(1)) begin
      nerr++; $display("[TB] FAIL ign_go_in_play: got turn %b start %b round %0d, expected 1 0 1",
                       player_turn, start, check_round);
    end
    guess(1'b1, 1'b0, 0, 1'b1, ptc);
    nvec++;
    if (ptc !== 1'b0 || player_turn !== 1'b1) begin
      nerr++; $display("[TB] FAIL ign_guess_pulse_priority: got check-turn %b turn %b, expected 0 1",
                       ptc, player_turn);
    end
  endtask

  task automatic test_timeout;
    int nLoad, nFlash; bit tmo, ptc;
    do_reset;
    start_game;
    tick;
    flash_phase(nLoad, nFlash, tmo);
`ifdef SIMON_TIMEOUT_EN
    for (int i = 1; i <= TP - 2; i++) begin
      pulse = 1'b1; tick; pulse = 1'b0;
      nvec++;
      if (player_turn !== 1'b1) begin
        nerr++; $display("[TB] FAIL to_early pulse %0d: got turn %b, expected 1", i, player_turn);
      end
    end
    guess(1'b1, 1'b0, 0, 1'b1, ptc);
    nvec++;
    if (player_turn !== 1'b1 || game_over !== 1'b0) begin
      nerr++; $display("[TB] FAIL to_guess_clear: got turn %b over %b, expected 1 0", player_turn, game_over);
    end
    for (int i = 1; i <= TP - 1; i++) begin
      pulse = 1'b1; tick; pulse = 1'b0;
      nvec++;
      if (player_turn !== 1'b1 || game_over !== 1'b0) begin
        nerr++; $display("[TB] FAIL to_count pulse %0d: got turn %b over %b, expected 1 0",
                         i, player_turn, game_over);
      end
    end
    pulse = 1'b1; tick; pulse = 1'b0;
    nvec++;
    if (game_over !== 1'b1 || win !== 1'b0 || player_turn !== 1'b0) begin
      nerr++; $display("[TB] FAIL to_expire: got over %b win %b turn %b, expected 1 0 0",
                       game_over, win, player_turn);
    end
`else
    for (int i = 1; i <= 3 * TP; i++) begin
      pulse = 1'b1; tick; pulse = 1'b0;
      nvec++;
      if (player_turn !== 1'b1 || game_over !== 1'b0) begin
        nerr++; $display("[TB] FAIL no_timeout pulse %0d: got turn %b over %b, expected 1 0",
                         i, player_turn, game_over);
      end
    end
    guess(1'b1, 1'b1, 0, 1'b0, ptc);
    nvec++;
    if (load_speed !== 1'b1 || check_round !== RW'(2)) begin
      nerr++; $display("[TB] FAIL no_timeout_advance: got ld %b round %0d, expected 1 2", load_speed, check_round);
    end
`endif
  endtask

  task automatic test_reset_mid_flash;
    int nLoad, nFlash; bit tmo, ptc, found;
    logic [7:0] outs;
    do_reset;
    start_game;
    tick;
    for (int r = 1; r <= 2; r++) begin
      flash_phase(nLoad, nFlash, tmo);
      for (int g = 0; g < r; g++) guess(1'b1, (g == r - 1), rand_pulses(), 1'b0, ptc);
    end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (flash_colour) begin found = 1'b1; break; end
    end
    nvec++;
    if (found !== 1'b1 || check_round !== RW'(3)) begin
      nerr++; $display("[TB] FAIL rmf_reach_flash: got found %b round %0d, expected 1 3", found, check_round);
    end
    rst = 1'b1;
    #1;
    outs = {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, game_over, win};
    nvec++;
    if (outs !== 8'h00 || check_round !== '0 || speed !== '0) begin
      nerr++; $display("[TB] FAIL rmf_async_clear: got %b round %0d speed %0d, expected 00000000 0 0",
                       outs, check_round, speed);
    end
    tick;
    rst = 1'b0;
    tick; tick;
    nvec++;
    if (check_round !== '0 || flash_colour !== 1'b0 || start !== 1'b0) begin
      nerr++; $display("[TB] FAIL rmf_idle_after: got round %0d flash %b start %b, expected 0 0 0",
                       check_round, flash_colour, start);
    end
    start_game;
    nvec++;
    if (start !== 1'b1 || check_round !== RW'(1) || speed !== '0) begin
      nerr++; $display("[TB] FAIL rmf_restart: got start %b round %0d speed %0d, expected 1 1 0",
                       start, check_round, speed);
    end
  endtask

  initial begin
    test_reset;
    test_perfect_game;
    test_lose_restart;
    test_ignored;
    test_timeout;
    test_reset_mid_flash;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
